// File: rtl/uart_rx_parity_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_parity_checker
//   Frame-aware UART receive parity checker. Collects DATA_WIDTH sampled bits
//   LSB-first after each frame_start_in, optionally checks a trailing parity
//   bit (even / odd / mark / space), then reports the assembled word with a
//   one-cycle data_valid_out pulse, a parity-error strobe and a saturating
//   error count. Sits between the RX bit sampler and the frame consumer.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   frame_start_in in   1-cycle pulse at end of start bit; arms a new frame
//   bit_valid_in   in   sampled_bit_in carries a valid bit this cycle
//   sampled_bit_in in   sampled serial bit
//   par_en_in      in   frame carries a parity bit (latched at frame start)
//   par_mode_in    in   00 even, 01 odd, 10 mark, 11 space (latched at start)
//   err_cnt_clr_in in   clears err_cnt_out (wins over a same-cycle increment)
//   data_out       out  assembled data word, held until the next completion
//   data_valid_out out  1-cycle pulse: frame complete, data_out updated
//   par_err_out    out  1-cycle pulse alongside data_valid_out on mismatch
//   busy_out       out  high while collecting data or parity bits
//   err_cnt_out    out  saturating count of parity errors
// -----------------------------------------------------------------------------
module uart_rx_parity_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start_in,
  input  logic                     bit_valid_in,
  input  logic                     sampled_bit_in,
  input  logic                     par_en_in,
  input  logic [1:0]               par_mode_in,
  input  logic                     err_cnt_clr_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid_out,
  output logic                     par_err_out,
  output logic                     busy_out,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, REPORT} state_t;

  function automatic logic expected_parity(input logic [1:0] mode, input logic acc);
    case (mode)
      2'b00:   return acc;
      2'b01:   return ~acc;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] sr_q, sr_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic                  xor_q, xor_nxt;
  logic                  par_en_q, par_en_nxt;
  logic [1:0]            par_mode_q, par_mode_nxt;
  logic                  report_nxt;
  logic                  err_nxt;

  // Next-state decode. frame_start_in overrides everything, including a
  // same-cycle bit, so aborts and back-to-back frames share one path.
  always_comb begin
    state_nxt    = state_q;
    sr_nxt       = sr_q;
    cnt_nxt      = cnt_q;
    xor_nxt      = xor_q;
    par_en_nxt   = par_en_q;
    par_mode_nxt = par_mode_q;
    report_nxt   = 1'b0;
    err_nxt      = 1'b0;
    if (frame_start_in) begin
      state_nxt    = DATA;
      sr_nxt       = '0;
      cnt_nxt      = '0;
      xor_nxt      = 1'b0;
      par_en_nxt   = par_en_in;
      par_mode_nxt = par_mode_in;
    end else begin
      case (state_q)
        DATA: begin
          if (bit_valid_in) begin
            sr_nxt  = {sampled_bit_in, sr_q[DATA_WIDTH-1:1]};
            xor_nxt = xor_q ^ sampled_bit_in;
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state_nxt = PARITY;
              end else begin
                state_nxt  = REPORT;
                report_nxt = 1'b1;
              end
            end
          end
        end
        PARITY: begin
          if (bit_valid_in) begin
            err_nxt    = (sampled_bit_in != expected_parity(par_mode_q, xor_q));
            state_nxt  = REPORT;
            report_nxt = 1'b1;
          end
        end
        REPORT:  state_nxt = IDLE;
        default: state_nxt = state_q;
      endcase
    end
  end

  // Register stage: report outputs are loaded on the same edge that enters
  // REPORT, so the pulses appear one cycle after the final valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      cnt_q          <= '0;
      xor_q          <= 1'b0;
      par_en_q       <= 1'b0;
      par_mode_q     <= 2'b00;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      par_err_out    <= 1'b0;
      busy_out       <= 1'b0;
      err_cnt_out    <= '0;
    end else begin
      state_q        <= state_nxt;
      sr_q           <= sr_nxt;
      cnt_q          <= cnt_nxt;
      xor_q          <= xor_nxt;
      par_en_q       <= par_en_nxt;
      par_mode_q     <= par_mode_nxt;
      data_valid_out <= report_nxt;
      par_err_out    <= report_nxt & err_nxt;
      busy_out       <= (state_nxt == DATA) || (state_nxt == PARITY);
      if (report_nxt) data_out <= sr_nxt;
      if (err_cnt_clr_in)              err_cnt_out <= '0;
      else if (report_nxt && err_nxt)  err_cnt_out <= sat_inc(err_cnt_out);
    end
  end

endmodule
